// File: rtl/lc3b_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline: cache waits, load-use
// bubbles and MEM-stage redirects, plus watchdog and saturating perf counters.
module lc3b_hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       id_sr1,
    input  logic             id_sr1_used,
    input  logic [2:0]       id_sr2,
    input  logic             id_sr2_used,
    input  logic             ex_load,
    input  logic [2:0]       ex_dest,
    input  logic             ex_dest_we,
    input  logic             i_req,
    input  logic             i_resp,
    input  logic             d_req,
    input  logic             d_resp,
    input  logic             mem_br_taken,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_exe_stall,
    output logic             exe_mem_stall,
    output logic             mem_wb_stall,
    output logic             if_id_flush,
    output logic             id_exe_flush,
    output logic             exe_mem_flush,
    output logic             mem_wb_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             timeout_err
);

    // state  | meaning
    // RUN    | no multi-cycle wait in progress
    // DWAIT  | MEM held until the D-cache completes
    // IDRAIN | redirect held until the in-flight fetch returns
    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DWAIT  = 2'd1;
    localparam logic [1:0] IDRAIN = 2'd2;

    localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] wait_cnt;

    logic c_dmiss, c_redir_blk, c_load_use, c_imiss;
    logic f_dmiss, f_redir_blk, f_redir, f_load_use, f_imiss;
    logic waiting;

    assign c_dmiss     = d_req & ~d_resp;
    assign c_imiss     = i_req & ~i_resp;
    assign c_redir_blk = mem_br_taken & c_imiss;
    assign c_load_use  = ex_load & ex_dest_we &
                         ((id_sr1_used & (id_sr1 == ex_dest)) |
                          (id_sr2_used & (id_sr2 == ex_dest)));

    // One-hot "rule that fires this cycle", first match wins.
    always_comb begin
        f_dmiss     = 1'b0;
        f_redir_blk = 1'b0;
        f_redir     = 1'b0;
        f_load_use  = 1'b0;
        f_imiss     = 1'b0;
        if (c_dmiss)           f_dmiss     = 1'b1;
        else if (c_redir_blk)  f_redir_blk = 1'b1;
        else if (mem_br_taken) f_redir     = 1'b1;
        else if (c_load_use)   f_load_use  = 1'b1;
        else if (c_imiss)      f_imiss     = 1'b1;
    end

    assign waiting = f_dmiss | f_redir_blk | f_imiss;

    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_exe_stall  = 1'b0;
        exe_mem_stall = 1'b0;
        mem_wb_stall  = 1'b0;
        if_id_flush   = 1'b0;
        id_exe_flush  = 1'b0;
        exe_mem_flush = 1'b0;
        mem_wb_flush  = 1'b0;
        if (!reset_n) begin
            if_id_flush   = 1'b1;
            id_exe_flush  = 1'b1;
            exe_mem_flush = 1'b1;
            mem_wb_flush  = 1'b1;
        end else if (f_dmiss || f_redir_blk) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_exe_stall  = 1'b1;
            exe_mem_stall = 1'b1;
            mem_wb_flush  = 1'b1;
        end else if (f_redir) begin
            if_id_flush   = 1'b1;
            id_exe_flush  = 1'b1;
            exe_mem_flush = 1'b1;
        end else if (f_load_use) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_exe_flush  = 1'b1;
        end else if (f_imiss) begin
            pc_stall      = 1'b1;
            if_id_flush   = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (f_dmiss)          state_nxt = DWAIT;
                else if (f_redir_blk) state_nxt = IDRAIN;
            end
            DWAIT: begin
                if (d_resp) state_nxt = f_redir_blk ? IDRAIN : RUN;
            end
            IDRAIN: begin
                // A D-miss here is not expected, but it must still be tracked.
                if (f_dmiss)     state_nxt = DWAIT;
                else if (i_resp) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= RUN;
            wait_cnt    <= 8'd0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!waiting)               wait_cnt <= 8'd0;
            else if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
            if (waiting && wait_cnt == WAIT_LAST) timeout_err <= 1'b1;
            if (pc_stall && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
            if (f_redir && flush_cnt != CNT_MAX)  flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
